// File: rtl/shift_unit.sv
// Multi-cycle programmable shifter (SLL/SRL/SRA/ROL) with start/busy/done handshake.
// Up to Step bit positions are shifted per clock; the result is held in out until the next completion.
module shift_unit #(
    parameter int Width = 32,
    parameter int Step  = 1,
    parameter int ShW   = $clog2(Width)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [Width-1:0] In,
    input  logic [ShW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } mode_t;

    // One extra bit so Step == Width (a power of two) is representable.
    localparam logic [ShW:0] StepV  = (ShW + 1)'(Step);
    localparam logic [ShW:0] WidthV = (ShW + 1)'(Width);

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [Width-1:0]   work_q, work_d;
    logic [ShW-1:0]     rem_q, rem_d;
    logic [Width-1:0]   out_d;
    logic [ShW:0]       rem_ext;
    logic [ShW:0]       step_n;
    logic [Width-1:0]   shifted;
    logic               accept;

    // Per-cycle shift by n = min(Step, remaining); n is never 0 while in SHIFT.
    always_comb begin
        rem_ext = {1'b0, rem_q};
        step_n  = (rem_ext > StepV) ? StepV : rem_ext;
        shifted = work_q;
        unique case (mode_q)
            SLL: shifted = work_q << step_n;
            SRL: shifted = work_q >> step_n;
            SRA: shifted = $signed(work_q) >>> step_n;
            ROL: shifted = (work_q << step_n) | (work_q >> (WidthV - step_n));
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        work_d  = work_q;
        rem_d   = rem_q;
        out_d   = out;
        accept  = start && (state_q != SHIFT);

        unique case (state_q)
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step_n[ShW-1:0];
                if (rem_q == step_n[ShW-1:0]) begin
                    out_d   = shifted;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // A request in IDLE or DONE overrides the default next state.
        if (accept) begin
            work_d = In;
            mode_d = mode_t'(mode);
            rem_d  = shamt;
            if (shamt == '0) begin
                out_d   = In;
                state_d = DONE;
            end else begin
                state_d = SHIFT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= SLL;
            work_q  <= '0;
            rem_q   <= '0;
            out     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            out     <= out_d;
            busy    <= (state_d == SHIFT);
            done    <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: three configurations (32/1, 32/4, 8/2) driven with
// directed and random requests, checked against a bit-level reference model.
module tb_shift_unit;

    logic clk;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input int inst, input bit ok, input string nm,
                                input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL [cfg%0d] %s: got %0h expected %0h at %0t", inst, nm, act, exp, $time);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int W  = (k == 2) ? 8 : 32;
        localparam int S  = (k == 0) ? 1 : ((k == 1) ? 4 : 2);
        localparam int SW = $clog2(W);

        logic          rst, start, busy, done;
        logic [1:0]    mode;
        logic [W-1:0]  din, out;
        logic [SW-1:0] shamt;

        int           cyc = 0;
        int           ready = 0;
        int           busy_lo = 1;
        int           busy_hi = 0;
        logic [W-1:0] last_out = '0;
        logic [W-1:0] qv[$];
        int           qc[$];
        bit           fin = 1'b0;

        shift_unit #(.Width(W), .Step(S)) dut (
            .clk   (clk),
            .reset (rst),
            .start (start),
            .mode  (mode),
            .In    (din),
            .shamt (shamt),
            .busy  (busy),
            .done  (done),
            .out   (out)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Reference: each result bit taken directly from its source position.
        function automatic logic [W-1:0] model(input logic [1:0] md, input logic [W-1:0] v, input int sh);
            logic [W-1:0] r;
            for (int i = 0; i < W; i++) begin
                case (md)
                    2'd0:    r[i] = (i >= sh) ? v[i-sh] : 1'b0;
                    2'd1:    r[i] = (i + sh < W) ? v[i+sh] : 1'b0;
                    2'd2:    r[i] = (i + sh < W) ? v[i+sh] : v[W-1];
                    default: r[i] = v[(i - sh + W) % W];
                endcase
            end
            return r;
        endfunction

        task automatic issue(input logic [1:0] md, input logic [W-1:0] v, input int sh);
            int lat;
            while (cyc < ready) @(negedge clk);
            lat   = (sh + S - 1) / S;
            start = 1'b1;
            mode  = md;
            din   = v;
            shamt = SW'(sh);
            qv.push_back(model(md, v, sh));
            qc.push_back(cyc + 1 + lat);
            busy_lo = cyc + 1;
            busy_hi = cyc + lat;
            ready   = cyc + 1 + lat;
            @(negedge clk);
            start = 1'b0;
            mode  = 2'($urandom);
            din   = W'($urandom);
            shamt = SW'($urandom);
        endtask

        task automatic poke();
            if (cyc >= busy_lo && cyc <= busy_hi) begin
                start = 1'b1;
                mode  = 2'($urandom);
                din   = W'($urandom);
                shamt = SW'($urandom_range(1, W - 1));
                @(negedge clk);
                start = 1'b0;
            end
        endtask

        // Monitor: sample one time unit after each active edge.
        initial begin
            logic [W-1:0] ev;
            int           ec;
            forever begin
                @(posedge clk);
                #1;
                chk(k, busy === (cyc >= busy_lo && cyc <= busy_hi), "busy", 64'(busy),
                    64'(cyc >= busy_lo && cyc <= busy_hi));
                while (qc.size() != 0 && qc[0] < cyc) begin
                    ec = qc.pop_front();
                    ev = qv.pop_front();
                    chk(k, 1'b0, "missing done", 64'(cyc), 64'(ec));
                end
                if (done === 1'b1) begin
                    if (qc.size() == 0) begin
                        chk(k, 1'b0, "unexpected done", 64'(out), 64'(last_out));
                    end else begin
                        ec = qc.pop_front();
                        ev = qv.pop_front();
                        chk(k, cyc == ec, "done cycle", 64'(cyc), 64'(ec));
                        chk(k, out === ev, "result", 64'(out), 64'(ev));
                        last_out = ev;
                    end
                end else begin
                    chk(k, out === last_out, "out hold", 64'(out), 64'(last_out));
                end
            end
        end

        initial begin
            logic [W-1:0] v, msb;
            int           gap, sh;
            rst   = 1'b1;
            start = 1'b0;
            mode  = '0;
            din   = '0;
            shamt = '0;
            repeat (2) @(negedge clk);
            rst = 1'b0;

            issue(2'd0, W'(1), 1);
            msb = '0;
            msb[W-1] = 1'b1;
            issue(2'd2, msb, W - 1);
            issue(2'd1, msb, W - 1);
            v = '0;
            v[W-1 -: 4] = 4'hF;
            issue(2'd1, v, 7);
            issue(2'd3, msb | W'(1), 4);
            issue(2'd3, W'(32'hDEAD_BEEF), 0);

            // Ignored starts mid-shift, then a back-to-back request in the DONE cycle.
            issue(2'd1, W'(32'hA5C3_0F96), W - 1);
            poke();
            poke();
            issue(2'd0, W'(32'h1234_5679), 5);
            issue(2'd2, W'(32'h8765_4321), 3);

            // Reset in the middle of a long SLL, with start held high during reset.
            issue(2'd0, W'(32'h0000_0F0F), (W > 20) ? 20 : W - 1);
            @(negedge clk);
            rst   = 1'b1;
            start = 1'b1;
            din   = W'(32'hFFFF_FFFF);
            shamt = SW'(1);
            qv.delete();
            qc.delete();
            busy_lo  = 1;
            busy_hi  = 0;
            last_out = '0;
            ready    = cyc + 1;
            @(posedge clk);
            #1;
            chk(k, busy === 1'b0, "reset busy", 64'(busy), 64'(0));
            chk(k, done === 1'b0, "reset done", 64'(done), 64'(0));
            chk(k, out === '0, "reset out", 64'(out), 64'(0));
            @(negedge clk);
            rst   = 1'b0;
            start = 1'b0;
            repeat (3) @(negedge clk);
            issue(2'd0, W'(1), 3);

            for (int i = 0; i < 100; i++) begin
                gap = $urandom_range(0, 3);
                if (gap > 1) begin
                    while (cyc < ready) @(negedge clk);
                    repeat (gap - 1) @(negedge clk);
                end
                sh = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, W - 1);
                issue(2'($urandom), W'($urandom), sh);
                if ($urandom_range(0, 2) == 0) poke();
            end

            while (cyc < ready + 2) @(negedge clk);
            chk(k, qc.size() == 0, "drain", 64'(qc.size()), 64'(0));
            fin = 1'b1;
        end
    end

    initial begin
        bit all_fin;
        all_fin = 1'b0;
        for (int t = 0; t < 80000 && !all_fin; t++) begin
            @(posedge clk);
            all_fin = g[0].fin && g[1].fin && g[2].fin;
        end
        chk(-1, all_fin, "timeout", 64'(all_fin), 64'(1));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
